// File: rtl/fp_fixed_pkg.sv
// ----------------------------------------------------------------------------
// fp_fixed_pkg
// Constants and types shared by the fp32 <-> S13.18 fixed-point converters.
// S13.18: 32-bit two's complement, value = Y / 2^18.
// No ports (package).
// ----------------------------------------------------------------------------
package fp_fixed_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FIX_FRAC = 18;
  // Exponent at which the 24-bit mantissa lands unshifted in S13.18:
  // 1.m * 2^(E-127) * 2^18 = m24 * 2^(E-127-23+18) = m24 << (E - 132).
  localparam int FIX_SHIFT_REF = FP_BIAS + 23 - FIX_FRAC;
  // |X| >= 2^13 no longer fits in the 13 integer bits.
  localparam logic [7:0] EXP_SAT = 8'd140;
  localparam logic [7:0] EXP_INF = 8'hFF;

  // Symmetric saturation: the negative limit is -(2^31 - 1), not -2^31.
  localparam logic [31:0] FIX_SAT_POS = 32'h7FFFFFFF;
  localparam logic [31:0] FIX_SAT_NEG = 32'h80000001;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    SAT  = 2'd2,
    NAN  = 2'd3
  } fx_class_e;

  // Classification order matters: inf/NaN share E = 255 with the
  // saturating range, so they are checked first.
  function automatic fx_class_e fx_classify(input logic [7:0] e,
                                            input logic [22:0] frac);
    if (e == EXP_INF)       return (frac != 23'd0) ? NAN : SAT;
    else if (e >= EXP_SAT)  return SAT;
    else if (e == 8'd0)     return ZERO;
    else                    return NORM;
  endfunction

endpackage

// File: rtl/fp32_to_fixed32_if.sv
// ----------------------------------------------------------------------------
// fp32_to_fixed32_if
// Operand and result handshakes of the fp32 -> S13.18 converter.
//   X, valid_in, ready_in       : operand channel (into the converter)
//   Y, sat, nan, valid_out,
//   ready_out                   : result channel (out of the converter)
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The sender holds its payload and valid stable until that edge; ready
// may change freely and carries no commitment on its own.
// modport slave  : converter view
// modport master : upstream/downstream (environment) view
// ----------------------------------------------------------------------------
interface fp32_to_fixed32_if;
  logic [31:0] X;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] Y;
  logic        sat;
  logic        nan;
  logic        valid_out;
  logic        ready_out;

  modport slave (
    input  X, valid_in, ready_out,
    output ready_in, Y, sat, nan, valid_out
  );

  modport master (
    output X, valid_in, ready_out,
    input  ready_in, Y, sat, nan, valid_out
  );
endinterface

// File: rtl/fp32_to_fixed32_fx_shift_round.sv
// ----------------------------------------------------------------------------
// fx_shift_round
// Combinational bidirectional barrel shifter: 24-bit mantissa -> 31-bit
// magnitude. Shift amount i_k is a 9-bit two's complement value:
// i_k >= 0 shifts left (only 0..7 occurs), i_k < 0 shifts right by -i_k.
// Build option FP2FX_ROUND_EN: round half away from zero in the right-shift
// path (adds the first bit shifted out); otherwise truncate.
//   i_m24 : {1, mantissa}
//   i_k   : signed shift amount
//   o_mag : unsigned magnitude, always < 2^31
// ----------------------------------------------------------------------------
module fx_shift_round (
  input  logic [23:0] i_m24,
  input  logic [8:0]  i_k,
  output logic [30:0] o_mag
);

  logic [8:0]  w_ramt;
  logic [30:0] w_lsh;
  logic [30:0] w_rmag;

  assign w_ramt = -i_k;
  // Left path: k <= 7 keeps the 24-bit mantissa within 31 bits.
  assign w_lsh  = {7'd0, i_m24} << i_k[2:0];

`ifdef FP2FX_ROUND_EN
  // One extra guard bit below the LSB carries the rounding increment; shifts
  // of 25+ clear everything, a shift of exactly 24 leaves only the guard.
  logic [24:0] w_rsh;
  assign w_rsh  = {i_m24, 1'b0} >> w_ramt;
  // Magnitude < 2^24 here, so the increment cannot overflow.
  assign w_rmag = {7'd0, w_rsh[24:1]} + {30'd0, w_rsh[0]};
`else
  logic [23:0] w_rsh;
  assign w_rsh  = i_m24 >> w_ramt;
  assign w_rmag = {7'd0, w_rsh};
`endif

  assign o_mag = i_k[8] ? w_rmag : w_lsh;

endmodule

// File: rtl/fp32_to_fixed32.sv
// ----------------------------------------------------------------------------
// fp32_to_fixed32
// 3-stage pipelined IEEE-754 single -> S13.18 fixed-point converter.
// Saturates |X| >= 8192 and +-inf symmetrically, flushes denormals to 0,
// returns 0 with nan = 1 for NaN.
// Build option FP2FX_ROUND_EN: round to nearest (half away from zero) on
// inputs below the S13.18 LSB grid; default build truncates.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   bus.slave : X/valid_in/ready_in operand channel,
//               Y/sat/nan/valid_out/ready_out result channel
// Stages: S1 classify + field split, S2 shift/round, S3 sign/saturate.
// One global enable stalls all stages together, so ready_in depends only on
// the output register and the downstream ready.
// ----------------------------------------------------------------------------
module fp32_to_fixed32
  import fp_fixed_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  fp32_to_fixed32_if.slave       bus
);

  logic        w_en;

  // S1
  logic        r1_valid;
  fx_class_e   r1_cls;
  logic        r1_sign;
  logic [23:0] r1_m24;
  logic [8:0]  r1_k;
  fx_class_e   w_cls;
  logic [8:0]  w_k;

  // S2
  logic        r2_valid;
  fx_class_e   r2_cls;
  logic        r2_sign;
  logic [30:0] r2_mag;
  logic [30:0] w_mag;

  // S3
  logic        r3_valid;
  logic [31:0] r3_y;
  logic        r3_sat;
  logic        r3_nan;
  logic [31:0] w_y;

  assign w_en         = bus.ready_out || !r3_valid;
  assign bus.ready_in = w_en;

  assign w_cls = fx_classify(bus.X[30:23], bus.X[22:0]);
  // k = E - 132 in 9-bit two's complement; bit 8 is the sign.
  assign w_k   = {1'b0, bus.X[30:23]} - 9'(FIX_SHIFT_REF);

  fx_shift_round u_shift (
    .i_m24 (r1_m24),
    .i_k   (r1_k),
    .o_mag (w_mag)
  );

  always_comb begin
    w_y = 32'd0;
    case (r2_cls)
      SAT:     w_y = r2_sign ? FIX_SAT_NEG : FIX_SAT_POS;
      NORM:    w_y = r2_sign ? (~{1'b0, r2_mag} + 32'd1) : {1'b0, r2_mag};
      default: w_y = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_cls   <= ZERO;
      r1_sign  <= 1'b0;
      r1_m24   <= 24'd0;
      r1_k     <= 9'd0;
      r2_valid <= 1'b0;
      r2_cls   <= ZERO;
      r2_sign  <= 1'b0;
      r2_mag   <= 31'd0;
      r3_valid <= 1'b0;
      r3_y     <= 32'd0;
      r3_sat   <= 1'b0;
      r3_nan   <= 1'b0;
    end else if (w_en) begin
      r1_valid <= bus.valid_in;
      r1_cls   <= w_cls;
      r1_sign  <= bus.X[31];
      r1_m24   <= {1'b1, bus.X[22:0]};
      r1_k     <= w_k;
      r2_valid <= r1_valid;
      r2_cls   <= r1_cls;
      r2_sign  <= r1_sign;
      r2_mag   <= w_mag;
      r3_valid <= r2_valid;
      r3_y     <= w_y;
      r3_sat   <= (r2_cls == SAT);
      r3_nan   <= (r2_cls == NAN);
    end
  end

  assign bus.Y         = r3_y;
  assign bus.sat       = r3_sat;
  assign bus.nan       = r3_nan;
  assign bus.valid_out = r3_valid;

endmodule
